bfly_ct_gs: RTL

BFLY_CT_GS -- requirements
Module: bfly_ct_gs

---
 rtl/ntt_pkg.sv | 19 +
 rtl/bfly_ct_gs_if.sv | 34 +++
 rtl/modmul_pipe.sv | 45 ++++
 rtl/bfly_ct_gs.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants and types for the NTT butterfly slice
// Purpose: default datapath width, prime modulus, its inverse of two,
//          multiplier pipeline depth and the butterfly mode enum.
// Ports:   none (package).
package ntt_pkg;

  localparam int                    DEFAULT_W       = 28;
  // 2^28 - 2^16 + 1
  localparam logic [DEFAULT_W-1:0]  DEFAULT_Q       = 28'd268369921;
  // (Q + 1) / 2, the multiplicative inverse of 2 mod DEFAULT_Q
  localparam logic [DEFAULT_W-1:0]  Q_HALF_INV      = 28'd134184961;
  localparam int                    DEFAULT_MUL_LAT = 5;

  typedef enum logic {
    BFLY_CT = 1'b0,
    BFLY_GS = 1'b1
  } bfly_mode_e;

endpackage

// File: rtl/bfly_ct_gs_if.sv
// rtl/bfly_ct_gs_if.sv - sample/result bundle for the CT/GS butterfly
// Purpose: groups the butterfly operand, result and twiddle-index signals.
// Ports (signals):
//   in_valid, mode, tw_restart, x_in, y_in : producer -> butterfly
//   out_valid, x_out, y_out, tw_idx        : butterfly -> consumer
// Modports: master drives operands, slave is the butterfly side.
interface bfly_ct_gs_if
  import ntt_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int IDX_W = 5
);

  logic             in_valid;
  bfly_mode_e       mode;
  logic             tw_restart;
  logic [W-1:0]     x_in;
  logic [W-1:0]     y_in;
  logic             out_valid;
  logic [W-1:0]     x_out;
  logic [W-1:0]     y_out;
  logic [IDX_W-1:0] tw_idx;

  modport master (
    output in_valid, mode, tw_restart, x_in, y_in,
    input  out_valid, x_out, y_out, tw_idx
  );

  modport slave (
    input  in_valid, mode, tw_restart, x_in, y_in,
    output out_valid, x_out, y_out, tw_idx
  );

endinterface

// File: rtl/modmul_pipe.sv
// rtl/modmul_pipe.sv - fixed-latency modular multiplier, p = (a*b) mod Q
// Purpose: free-running pipeline, no handshake; result appears MUL_LAT
//          cycles after the operands are presented.
// Ports:
//   clk  : clock
//   a_i  : operand a, W bits, < Q
//   b_i  : operand b, W bits, < Q
//   p_o  : product mod Q, W bits
module modmul_pipe #(
  parameter int           W       = 28,
  parameter logic [W-1:0] Q       = 28'd268369921,
  parameter int           MUL_LAT = 5
) (
  input  logic         clk,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] p_o
);

  localparam int PW = 2 * W;

  generate
    if (MUL_LAT == 1) begin : g_single
      logic [W-1:0] p_q;
      always_ff @(posedge clk) begin
        p_q <= W'((PW'(a_i) * PW'(b_i)) % PW'(Q));
      end
      assign p_o = p_q;
    end else begin : g_multi
      // Product is registered first, reduction is done in the second
      // stage, and any remaining depth is a plain retiming delay.
      logic [PW-1:0] prod_q;
      logic [W-1:0]  red_q [MUL_LAT-1];
      always_ff @(posedge clk) begin
        prod_q   <= PW'(a_i) * PW'(b_i);
        red_q[0] <= W'(prod_q % PW'(Q));
        for (int i = 1; i < MUL_LAT - 1; i++) begin
          red_q[i] <= red_q[i-1];
        end
      end
      assign p_o = red_q[MUL_LAT-2];
    end
  endgenerate

endmodule

// File: rtl/bfly_ct_gs.sv
// rtl/bfly_ct_gs.sv - pipelined Cooley-Tukey / Gentleman-Sande NTT butterfly
// Purpose: per-sample selectable CT or GS butterfly with an internal
//          twiddle sequencer; latency MUL_LAT+2 for both modes.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : bfly_ct_gs_if.slave (in_valid, mode, tw_restart, x_in, y_in,
//          out_valid, x_out, y_out, tw_idx)
// Build option: BFLY_GS_HALF_EN scales GS results by 2^-1 mod Q.
module bfly_ct_gs
  import ntt_pkg::*;
#(
  parameter int                         W        = DEFAULT_W,
  parameter logic [W-1:0]               Q        = W'(DEFAULT_Q),
  parameter int                         MUL_LAT  = DEFAULT_MUL_LAT,
  parameter int                         TW_DEPTH = 32,
  parameter logic [TW_DEPTH-1:0][W-1:0] TWIDDLES = {TW_DEPTH{W'(1)}},
  parameter int                         START    = 0,
  parameter int                         REPEAT   = 1
) (
  input logic        clk,
  input logic        rst,
  bfly_ct_gs_if.slave bus
);

  localparam int IDX_W = $clog2(TW_DEPTH);

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} - {1'b0, b};
    // top bit set means the difference went negative
    if (s[W]) s = s + {1'b0, Q};
    return s[W-1:0];
  endfunction

`ifdef BFLY_GS_HALF_EN
  function automatic logic [W-1:0] mod_half(input logic [W-1:0] v);
    logic [W:0] s;
    s = v[0] ? ({1'b0, v} + {1'b0, Q}) : {1'b0, v};
    return s[W:1];
  endfunction
`endif

  // Twiddle sequencer: warm-up count, repeat count, table index.
  logic [31:0]      pre_cnt_q, pre_cnt_d;
  logic [31:0]      rep_cnt_q, rep_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    rep_cnt_d = rep_cnt_q;
    idx_d     = idx_q;
    if (bus.tw_restart) begin
      pre_cnt_d = '0;
      rep_cnt_d = '0;
      idx_d     = '0;
    end else if (bus.in_valid) begin
      if (pre_cnt_q < 32'(START)) begin
        pre_cnt_d = pre_cnt_q + 32'd1;
      end else if (rep_cnt_q == 32'(REPEAT - 1)) begin
        rep_cnt_d = '0;
        idx_d     = idx_q + 1'b1;  // power-of-two depth wraps for free
      end else begin
        rep_cnt_d = rep_cnt_q + 32'd1;
      end
    end
  end

  // Stage A: GS does its add/sub up front so both modes feed the
  // multiplier at the same point and share one latency.
  logic [W-1:0] keep_in, mul_in;
  always_comb begin
    keep_in = bus.x_in;
    mul_in  = bus.y_in;
    if (bus.mode == BFLY_GS) begin
      keep_in = mod_add(bus.x_in, bus.y_in);
      mul_in  = mod_sub(bus.x_in, bus.y_in);
    end
  end

  logic         a_valid_q;
  logic         a_mode_q;
  logic [W-1:0] a_keep_q, a_mul_q, a_w_q;

  // Side-band delay line matching the multiplier depth.
  logic         d_valid_q [MUL_LAT];
  logic         d_mode_q  [MUL_LAT];
  logic [W-1:0] d_keep_q  [MUL_LAT];

  logic [W-1:0] prod;

  modmul_pipe #(
    .W       (W),
    .Q       (Q),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk (clk),
    .a_i (a_mul_q),
    .b_i (a_w_q),
    .p_o (prod)
  );

  // Final stage: CT does its add/sub after the product, GS passes through.
  logic [W-1:0] x_d, y_d;
  logic [W-1:0] fin_keep;
  always_comb begin
    fin_keep = d_keep_q[MUL_LAT-1];
    x_d      = fin_keep;
    y_d      = prod;
    if (d_mode_q[MUL_LAT-1] == BFLY_CT) begin
      x_d = mod_add(fin_keep, prod);
      y_d = mod_sub(fin_keep, prod);
    end else begin
`ifdef BFLY_GS_HALF_EN
      x_d = mod_half(fin_keep);
      y_d = mod_half(prod);
`else
      x_d = fin_keep;
      y_d = prod;
`endif
    end
  end

  logic         out_valid_q;
  logic [W-1:0] x_out_q, y_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      idx_q       <= '0;
      a_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      for (int i = 0; i < MUL_LAT; i++) d_valid_q[i] <= 1'b0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      idx_q       <= idx_d;
      a_valid_q   <= bus.in_valid;
      d_valid_q[0] <= a_valid_q;
      for (int i = 1; i < MUL_LAT; i++) d_valid_q[i] <= d_valid_q[i-1];
      out_valid_q <= d_valid_q[MUL_LAT-1];
      x_out_q     <= x_d;
      y_out_q     <= y_d;
    end
  end

  // Data path needs no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    a_mode_q    <= bus.mode;
    a_keep_q    <= keep_in;
    a_mul_q     <= mul_in;
    a_w_q       <= TWIDDLES[idx_q];
    d_mode_q[0] <= a_mode_q;
    d_keep_q[0] <= a_keep_q;
    for (int i = 1; i < MUL_LAT; i++) begin
      d_mode_q[i] <= d_mode_q[i-1];
      d_keep_q[i] <= d_keep_q[i-1];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.x_out     = x_out_q;
  assign bus.y_out     = y_out_q;
  assign bus.tw_idx    = idx_q;

endmodule
